rx_mod: RTL and testbench
=========================

# rx_mod

UART receiver, the receive-side counterpart of the controller's transmitter. Deserialises an 8N1 frame (1 start bit = 0, 8 data bits LSB first, 1 stop bit = 1) from the asynchronous `rxd` line using a 16x-oversampling tick. Presents the byte on `dout` with a valid/acknowledge handshake. Sits between the pad and the controller's host-side register/FIFO logic.

## Interface
- `OVERSAMPLE`, 16: ticks per bit; even, at least 8. `MID` = `OVERSAMPLE/2 - 1`.
- `clk`, in, 1: system clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-low reset.
- `bclk`, in, 1: oversample tick; one `clk` wide, `OVERSAMPLE` pulses per bit time.
- `rxd`, in, 1: serial line, asynchronous, idles at 1.
- `rx_ack`, in, 1: host has consumed `dout`; one-cycle pulse.
- `dout`, out, 8: last good byte received.
- `rx_valid`, out, 1: `dout` holds an unconsumed byte.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled as 0.
- `overrun`, out, 1: one-cycle pulse when a good byte completes while `rx_valid` = 1.

## Operation
- `rxd` passes through a 2-flop synchroniser; `rxs` is the synchronised line, and the previous `rxs` value is kept for edge detection.
- Tick counter `tcnt`, range 0..`OVERSAMPLE-1`, advances only on `bclk`. The bit counter `bcnt` is 3 bits wide.
- **IDLE**:
  - Condition: a falling edge on `rxs`.
  - Action: clear `tcnt` to 0, go to START.
- **START**:
  - At the decision tick (`tcnt == MID`), `rxs` = 0 moves to DATA with `bcnt` = 0.
  - `rxs` = 1 at the decision tick is a glitch: return to IDLE with no outputs.
  - `tcnt` wraps at `OVERSAMPLE-1`.
- **DATA**:
  - At each decision tick, shift `sr <= {bit, sr[7:1]}`.
  - After the bit with `bcnt == 7`, go to STOP; otherwise `bcnt++`.
- **STOP**, at the decision tick:
  - Stop bit = 1: load `dout <= sr` and set `rx_valid`. Pulse `overrun` if `rx_valid` was already 1; the new byte overwrites the old one.
  - Stop bit = 0: pulse `frame_err`. `dout` and `rx_valid` are unchanged and the byte is discarded.
  - In both cases, go to IDLE.
  - Because STOP exits at mid-stop-bit, a start edge that follows immediately is caught. After a break (line held low), a new frame needs `rxs` to return to 1 and then fall.
- **Handshake**:
  - `rx_ack` clears `rx_valid` on the next edge.
  - If `rx_ack` and a new good byte occur in the same cycle, `rx_valid` stays 1, `dout` takes the new byte, and there is no `overrun`.
  - `rx_ack` while `rx_valid` = 0 is ignored.
- **Reset** (`rst` = 0 at an edge), including mid-frame:
  - Go to IDLE; `tcnt`, `bcnt` and `sr` = 0.
  - `dout` = 8'h00, `rx_valid` = 0, `frame_err` = 0, `overrun` = 0.
  - Synchroniser flops = 1.

## Timing
- Synchroniser latency is 2 `clk` from `rxd` to `rxs`.
- Decision tick is `tcnt == MID` (7 for `OVERSAMPLE` = 16), which is mid-bit because `tcnt` is cleared at the start edge.
- `rx_valid`, `frame_err` and `overrun` change on the `clk` edge that processes the stop-bit decision tick. The pulses are exactly one `clk` wide.
- Frame-start to `rx_valid` is 9.5 bit times plus 3 `clk`, plus 1 tick when `RX_MAJORITY_EN` is defined.
- Tolerates ±4% baud mismatch at `OVERSAMPLE` = 16.

## Configuration
- `RX_MAJORITY_EN` defined:
  - Every bit (start, data, stop) is the 2-of-3 majority of `rxs` sampled at ticks `MID-1`, `MID` and `MID+1`.
  - The decision tick moves to `MID+1`.
- Undefined: single sample at `MID`.

## Structure
- Package `uart_pkg` holds:
  - State encoding: IDLE=2'b00, START=2'b01, DATA=2'b10, STOP=2'b11, shared with the transmitter.
  - `START_BIT`=0, `STOP_BIT`=1, `DATA_BITS`=8, the `OVERSAMPLE` default.
- Sub-module `sync_2ff`: parameterised width, reset value 1, reused by other async inputs.

## Test plan
- **Reset**: `rst`=0 with `rxd` toggling -> all outputs 0, state IDLE; release, idle line -> no activity.
- **Good byte**: 8'hA5 sent at exact baud -> `dout`=8'hA5, `rx_valid`=1; `rx_ack` -> `rx_valid`=0 next cycle; no `frame_err`/`overrun`.
- **Glitch start**: `rxd` low for 4 ticks, then high -> no `rx_valid`, returns to IDLE; a following 8'h3C frame is received correctly.
- **Frame error**: 8'h3C with stop=0 -> one-cycle `frame_err`, `dout` keeps its previous value, `rx_valid` unchanged.
- **Overrun**: 8'h11 then 8'h22 back-to-back, no ack -> `overrun` pulse at the second stop, `dout`=8'h22, `rx_valid`=1.
- **Robustness**:
  - Reset mid-DATA -> clean IDLE, and the next frame 8'h5A is received.
  - With `RX_MAJORITY_EN`, a 1-tick glitch at `MID` on bit 3 -> byte still correct.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, frame constants and helpers
// used by both the transmitter and the receiver.
package uart_pkg;

  typedef logic [1:0] uart_state_t;

  localparam uart_state_t ST_IDLE  = 2'b00;
  localparam uart_state_t ST_START = 2'b01;
  localparam uart_state_t ST_DATA  = 2'b10;
  localparam uart_state_t ST_STOP  = 2'b11;

  localparam logic START_BIT      = 1'b0;
  localparam logic STOP_BIT       = 1'b1;
  localparam int   DATA_BITS      = 8;
  localparam int   OVERSAMPLE_DEF = 16;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for asynchronous inputs; flops reset to RST_VAL
// (all ones by default so an idle-high line does not fake an edge).
module sync_2ff #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_meta;
  logic [W-1:0] r_sync;

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_meta <= RST_VAL;
      r_sync <= RST_VAL;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/rx_mod.sv
// 8N1 UART receiver with 16x (OVERSAMPLE) tick, valid/ack output handshake.
// Define RX_MAJORITY_EN for 2-of-3 sampling around mid-bit.
module rx_mod
  import uart_pkg::*;
#(
  parameter int OVERSAMPLE = OVERSAMPLE_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       bclk,
  input  logic       rxd,
  input  logic       rx_ack,
  output logic [7:0] dout,
  output logic       rx_valid,
  output logic       frame_err,
  output logic       overrun
);

  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] MID = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] TOP = TW'(OVERSAMPLE - 1);
`ifdef RX_MAJORITY_EN
  localparam logic [TW-1:0] DEC = TW'(OVERSAMPLE / 2);
`else
  localparam logic [TW-1:0] DEC = MID;
`endif

  logic                 w_rxs;
  logic                 w_dec;
  logic                 w_bit;
  logic                 r_rxs_d;
  uart_state_t          r_state;
  logic [TW-1:0]        r_tcnt;
  logic [2:0]           r_bcnt;
  logic [DATA_BITS-1:0] r_sr;

  sync_2ff #(.W(1), .RST_VAL(1'b1)) u_sync (
    .clk (clk),
    .rst (rst),
    .i_d (rxd),
    .o_q (w_rxs)
  );

  assign w_dec = bclk && (r_tcnt == DEC);

`ifdef RX_MAJORITY_EN
  logic r_s0;
  logic r_s1;

  // Early samples at MID-1 and MID; the third is the live line at MID+1.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_s0 <= 1'b1;
      r_s1 <= 1'b1;
    end else if (bclk) begin
      if (r_tcnt == MID - 1'b1) r_s0 <= w_rxs;
      if (r_tcnt == MID)        r_s1 <= w_rxs;
    end
  end

  assign w_bit = maj3(r_s0, r_s1, w_rxs);
`else
  assign w_bit = w_rxs;
`endif

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_rxs_d   <= 1'b1;
      r_state   <= ST_IDLE;
      r_tcnt    <= '0;
      r_bcnt    <= '0;
      r_sr      <= '0;
      dout      <= 8'h00;
      rx_valid  <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      r_rxs_d   <= w_rxs;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
      if (rx_ack) rx_valid <= 1'b0;

      if (r_state != ST_IDLE && bclk)
        r_tcnt <= (r_tcnt == TOP) ? '0 : r_tcnt + 1'b1;

      case (r_state)
        ST_IDLE: begin
          if (r_rxs_d && !w_rxs) begin
            r_tcnt  <= '0;
            r_state <= ST_START;
          end
        end
        ST_START: begin
          if (w_dec) begin
            if (w_bit == START_BIT) begin
              r_state <= ST_DATA;
              r_bcnt  <= '0;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        end
        ST_DATA: begin
          if (w_dec) begin
            r_sr <= {w_bit, r_sr[DATA_BITS-1:1]};
            if (r_bcnt == 3'(DATA_BITS - 1)) r_state <= ST_STOP;
            else                             r_bcnt  <= r_bcnt + 1'b1;
          end
        end
        default: begin
          // Leave at mid-stop-bit so a back-to-back start edge is not missed.
          if (w_dec) begin
            if (w_bit == STOP_BIT) begin
              dout     <= r_sr;
              rx_valid <= 1'b1;
              overrun  <= rx_valid && !rx_ack;
            end else begin
              frame_err <= 1'b1;
            end
            r_state <= ST_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_mod.sv
// Directed + randomized bench for rx_mod; frame-level reference model tracks
// expected byte, valid flag and pulse counts.
module tb_rx_mod;

  localparam int TICK_CLK = 4;
  localparam int BIT_CLK  = 16 * TICK_CLK;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       bclk = 1'b0;
  logic       rxd = 1'b1;
  logic       rx_ack = 1'b0;
  logic [7:0] dout;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;

  int tests = 0;
  int fails = 0;
  int fe_cnt = 0;
  int ov_cnt = 0;
  int cyc = 0;
  int rv_rise = 0;
  logic rv_q = 1'b0;

  logic [7:0] m_dout;
  logic       m_valid;
  int         m_fe;
  int         m_ov;

  rx_mod #(.OVERSAMPLE(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .bclk      (bclk),
    .rxd       (rxd),
    .rx_ack    (rx_ack),
    .dout      (dout),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 clk = ~clk;

  initial begin
    int d;
    d = 0;
    forever begin
      @(negedge clk);
      bclk = (d == TICK_CLK - 1);
      d = (d + 1) % TICK_CLK;
    end
  end

  // Pulse counters: a pulse longer than one cycle shows up as an extra count.
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (frame_err === 1'b1) fe_cnt <= fe_cnt + 1;
    if (overrun === 1'b1)   ov_cnt <= ov_cnt + 1;
    if (rx_valid === 1'b1 && rv_q !== 1'b1) rv_rise <= cyc;
    rv_q <= rx_valid;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_bit(input logic v);
    rxd = v;
    repeat (BIT_CLK) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit(stop);
  endtask

  task automatic model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      if (m_valid) m_ov++;
      m_dout  = b;
      m_valid = 1'b1;
    end else begin
      m_fe++;
    end
  endtask

  task automatic pulse_ack();
    rx_ack = 1'b1;
    @(negedge clk);
    rx_ack = 1'b0;
    m_valid = 1'b0;
  endtask

  task automatic check_all(input string tag);
    chk({tag, "_dout"},  32'(dout),     32'(m_dout));
    chk({tag, "_valid"}, 32'(rx_valid), 32'(m_valid));
    chk({tag, "_fe"},    fe_cnt,        m_fe);
    chk({tag, "_ov"},    ov_cnt,        m_ov);
  endtask

  initial begin
    int t0;
    logic [7:0] b;
    logic stop;

    m_dout = 8'h00; m_valid = 1'b0; m_fe = 0; m_ov = 0;

    // Reset with a toggling line
    rst = 1'b0;
    for (int i = 0; i < 24; i++) begin
      rxd = i[1];
      @(negedge clk);
    end
    chk("rst_dout",  32'(dout),      32'h0);
    chk("rst_valid", 32'(rx_valid),  32'h0);
    chk("rst_fe",    32'(frame_err), 32'h0);
    chk("rst_ov",    32'(overrun),   32'h0);
    rxd = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    send_bit(1'b1); send_bit(1'b1);
    check_all("idle");

    // Good byte plus latency and ack
    t0 = cyc;
    send_frame(8'hA5, 1'b1);
    model_frame(8'hA5, 1'b1);
    check_all("a5");
    chk("a5_latency_ok", 32'((rv_rise - t0) >= 605 && (rv_rise - t0) <= 618), 32'h1);
    pulse_ack();
    chk("ack_clears", 32'(rx_valid), 32'h0);
    pulse_ack();
    chk("ack_idle_ignored", 32'(rx_valid), 32'h0);
    send_bit(1'b1);

    // Glitch start, then a real frame
    rxd = 1'b0;
    repeat (4 * TICK_CLK) @(negedge clk);
    send_bit(1'b1); send_bit(1'b1);
    check_all("glitch");
    send_frame(8'h3C, 1'b1);
    model_frame(8'h3C, 1'b1);
    check_all("after_glitch");
    send_bit(1'b1);

    // Frame error keeps the previous byte
    send_frame(8'h81, 1'b1);
    model_frame(8'h81, 1'b1);
    send_bit(1'b1);
    send_frame(8'h3C, 1'b0);
    model_frame(8'h3C, 1'b0);
    check_all("frame_err");
    send_bit(1'b1);

    // Overrun on back-to-back bytes
    pulse_ack();
    send_frame(8'h11, 1'b1);
    model_frame(8'h11, 1'b1);
    send_frame(8'h22, 1'b1);
    model_frame(8'h22, 1'b1);
    check_all("overrun");
    send_bit(1'b1);

    // Reset mid-DATA
    send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rxd = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    m_dout = 8'h00; m_valid = 1'b0;
    chk("midrst_dout",  32'(dout),     32'h0);
    chk("midrst_valid", 32'(rx_valid), 32'h0);
    send_bit(1'b1);
    send_frame(8'h5A, 1'b1);
    model_frame(8'h5A, 1'b1);
    check_all("after_midrst");
    send_bit(1'b1);

`ifdef RX_MAJORITY_EN
    // One-tick glitch in the middle of data bit 3
    pulse_ack();
    b = 8'hA5;
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) begin
      if (i == 3) begin
        rxd = b[i];
        repeat (29) @(negedge clk);
        rxd = ~b[i];
        repeat (TICK_CLK) @(negedge clk);
        rxd = b[i];
        repeat (BIT_CLK - 29 - TICK_CLK) @(negedge clk);
      end else begin
        send_bit(b[i]);
      end
    end
    send_bit(1'b1);
    model_frame(b, 1'b1);
    check_all("maj_glitch");
    send_bit(1'b1);
`endif

    // Randomized frames, acks and stop-bit errors
    for (int n = 0; n < 16; n++) begin
      if ($urandom_range(1, 0) == 1) pulse_ack();
      b    = 8'($urandom);
      stop = ($urandom_range(4, 0) != 0);
      send_frame(b, stop);
      model_frame(b, stop);
      check_all($sformatf("rnd%0d", n));
      if (!stop || $urandom_range(1, 0) == 1) send_bit(1'b1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
